// File: rtl/count_event_logger.sv
// rtl/count_event_logger.sv - timestamped event logger for the clk1 8-bit counter
// Detects match-A entry, match-B entry and FF->00 wrap on each count_valid
// sample, queues {code, count, ts} in a show-ahead FIFO and pulses trig_*.
// Optional macro: EVLOG_OVERWRITE_EN (push while full replaces the oldest entry).
module count_event_logger #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk1,
  input  logic                     reset1,
  input  logic [7:0]               count_in,
  input  logic                     count_valid,
  input  logic [7:0]               match_a,
  input  logic [7:0]               match_b,
  input  logic                     arm,
  input  logic                     ts_clear,
  input  logic                     pop,
  output logic [31:0]              out_word,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     armed,
  output logic                     trig_a,
  output logic                     trig_b,
  output logic                     trig_wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            arm_d;
  logic            arm_rise;
  logic            load_prev;
  logic            sample_en;
  logic [7:0]      prev;
  logic            prev_valid;
  logic [TS_W-1:0] ts;

  logic            ev_a, ev_b, ev_w, push;
  logic [31:0]     entry;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]   level_q, level_nxt;
  logic [31:0]     head_q, head_nxt;
  logic            do_pop, wr_en, rd_adv, lvl_inc, ovf_set;
  logic            fifo_empty, fifo_full;

  assign arm_rise = arm & ~arm_d;

  // State register plus arm edge history
  always_ff @(posedge clk1) begin
    if (reset1) begin
      state <= S_IDLE;
      arm_d <= 1'b0;
    end else begin
      state <= state_nxt;
      arm_d <= arm;
    end
  end

  // Next-state: dropping arm always returns to IDLE; PRIME consumes one sample
  always_comb begin
    state_nxt = state;
    load_prev = 1'b0;
    sample_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_rise) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!arm) begin
          state_nxt = S_IDLE;
        end else if (count_valid) begin
          state_nxt = S_ARMED;
          load_prev = 1'b1;
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_nxt = S_IDLE;
        end else if (count_valid) begin
          sample_en = 1'b1;
          load_prev = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Previous sample; only meaningful once PRIME has loaded it
  always_ff @(posedge clk1) begin
    if (reset1) begin
      prev       <= 8'h00;
      prev_valid <= 1'b0;
    end else begin
      if (load_prev) prev <= count_in;
      if (state_nxt == S_IDLE) prev_valid <= 1'b0;
      else if (load_prev)      prev_valid <= 1'b1;
    end
  end

  // Free-running timestamp; a clear still lets this edge's sample see the old value
  always_ff @(posedge clk1) begin
    if (reset1 || ts_clear) ts <= '0;
    else                    ts <= ts + 1'b1;
  end

  // Event decode; simultaneous events merge into a single entry
  always_comb begin
    ev_a  = sample_en && prev_valid && (count_in == match_a) && (prev != match_a);
    ev_b  = sample_en && prev_valid && (count_in == match_b) && (prev != match_b);
    ev_w  = sample_en && prev_valid && (prev == 8'hFF) && (count_in == 8'h00);
    push  = ev_a | ev_b | ev_w;
    entry = {ev_w, ev_b, ev_a, 5'b0, count_in, ts};
  end

  // Event pulses, independent of FIFO acceptance
  always_ff @(posedge clk1) begin
    if (reset1) begin
      trig_a    <= 1'b0;
      trig_b    <= 1'b0;
      trig_wrap <= 1'b0;
    end else begin
      trig_a    <= ev_a;
      trig_b    <= ev_b;
      trig_wrap <= ev_w;
    end
  end

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);

  // FIFO control: decide write, read advance, level change and overflow
  always_comb begin
    do_pop  = pop && !fifo_empty;
    wr_en   = 1'b0;
    rd_adv  = do_pop;
    lvl_inc = 1'b0;
    ovf_set = 1'b0;
    if (push) begin
      if (!fifo_full || do_pop) begin
        wr_en   = 1'b1;
        lvl_inc = 1'b1;
      end else begin
        ovf_set = 1'b1;
`ifdef EVLOG_OVERWRITE_EN
        wr_en   = 1'b1;
        rd_adv  = 1'b1;
`endif
      end
    end
    rd_nxt = rd_adv ? rd_ptr + 1'b1 : rd_ptr;
    case ({lvl_inc, do_pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  // Show-ahead head: bypass the entry being written when it becomes the head
  always_comb begin
    head_nxt = head_q;
    if (level_nxt != '0) begin
      if (wr_en && (rd_nxt == wr_ptr)) head_nxt = entry;
      else                             head_nxt = mem[rd_nxt];
    end
  end

  // Entry storage (no reset needed: pointers and level define validity)
  always_ff @(posedge clk1) begin
    if (wr_en && !reset1) mem[wr_ptr] <= entry;
  end

  // Pointers, level, head register and sticky overflow
  always_ff @(posedge clk1) begin
    if (reset1) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nxt;
      level_q <= level_nxt;
      head_q  <= head_nxt;
      if (arm_rise)     overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  assign out_word = head_q;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign level    = level_q;
  assign armed    = (state == S_ARMED);

endmodule

// File: doc/count_event_logger.md
Name: count_event_logger

Overview:
- Sits directly downstream of the clk1-domain 8-bit counter. Consumes its count value and update strobe.
- Detects three events: match-A entry, match-B entry and FF->00 wrap.
- Timestamps each event and queues it in a small FIFO for the host to drain through wire/trigger endpoints.
- Also emits single-cycle event pulses suitable for direct connection to an okTriggerOut on clk1.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- TS_W, 16, timestamp width; fixed 16 for the 32-bit out_word packing.

Ports:
- clk1  in  1  block clock (the counter's clock)
- reset1  in  1  synchronous, active-high reset
- count_in  in  8  counter value
- count_valid  in  1  one-cycle strobe: count_in holds a new value this cycle
- match_a  in  8  match value A (quasi-static, from a wire-in)
- match_b  in  8  match value B (quasi-static)
- arm  in  1  level; logging enabled while high
- ts_clear  in  1  one-cycle pulse; zeroes the timestamp
- pop  in  1  one-cycle pulse; discards the FIFO head
- out_word  out  32  head entry: {code[2:0], 5'b0, count[7:0], ts[15:0]}
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  $clog2(DEPTH)+1  entry count
- overflow  out  1  sticky; cleared only by reset1 or an arm rising edge
- armed  out  1  state==ARMED
- trig_a, trig_b, trig_wrap  out  1 each  one-cycle event pulses

Behaviour:
- Reset (reset1=1 at an edge):
  - State IDLE; FIFO pointers and level 0; empty=1, full=0, overflow=0.
  - out_word=0, all trig_* = 0, ts=0, prev_valid=0.
- Timestamp:
  - Free-running TS_W counter, +1 every clk1 cycle, wraps FFFF->0000.
  - ts_clear forces 0 at the next edge; that edge's sample uses the pre-clear ts.
- States: IDLE, PRIME, ARMED.
  - IDLE -> PRIME on arm rising edge (arm=1, arm_d=0). This edge also clears overflow.
  - PRIME -> ARMED on the first count_valid: loads prev=count_in, records no event.
  - PRIME/ARMED -> IDLE whenever arm=0 at an edge. FIFO contents are retained.
- Event detection, ARMED only, on a count_valid sample:
  - a = (count_in==match_a) && (prev!=match_a)
  - b = (count_in==match_b) && (prev!=match_b)
  - w = (prev==8'hFF) && (count_in==8'h00)
  - prev updates on every count_valid while in ARMED.
  - If any of a/b/w is set, exactly one entry is pushed: code={w,b,a}, count=count_in, ts = ts value at the sample edge.
  - Simultaneous events in one sample combine into one entry. match_a==match_b gives code 3'b011.
- Latency:
  - Sample at edge E: the entry is written at E.
  - empty/level/full/out_word reflect it after E.
  - trig_* assert for exactly the one cycle following E, regardless of FIFO state.
- FIFO, show-ahead:
  - out_word always presents the head entry. Value is don't-care while empty; an implementation holds the last value.
  - pop while empty is ignored.
  - Push and pop in the same cycle while non-empty: both happen, level unchanged.
  - Push and pop in the same cycle while empty: push only.
  - Push while full with no pop in that cycle: entry dropped, overflow set (see Optional Feature).
  - Push while full with pop in that cycle: accepted, no overflow.
  - Pointers wrap modulo DEPTH.
- Count wrap with prev=FF while in PRIME: no event (prev is not yet valid).
- reset1 mid-operation: everything returns to the reset state on that edge; in-flight events are lost.

Optional Feature:
- Macro: EVLOG_OVERWRITE_EN.
- Defined: a push while full with no pop discards the oldest entry (read pointer +1) and stores the new one.
  - level stays DEPTH.
  - overflow is still set.
  - out_word advances to the next-oldest entry.
- Undefined: new entry is dropped, existing contents unchanged.

Test Plan:
- Reset: reset1 high 2 cycles -> empty=1, level=0, overflow=0, armed=0, out_word=0, trig_*=0.
- Match A, single entry: match_a=8'h05, arm=1, feed counts 00..07, pushes recorded at ts 100..107 -> count 00 primes only, no entry for it. Exactly one entry {3'b001, 5'b0, 8'h05, ts of the 05 sample}. trig_a high one cycle after that sample.
- Wrap with coincident match B: match_b=8'h00, counts FE,FF,00 -> one entry, code 3'b110, count 00. trig_wrap and trig_b high in the same cycle.
- Overflow: DEPTH=16, generate 17 events with no pop -> full=1, level=16, overflow=1.
  - Without the macro: drain 16 pops, getting entries 1..16, then empty=1.
  - With EVLOG_OVERWRITE_EN: the drain yields entries 2..17.
- Simultaneous push/pop at full: level=16, push and pop in the same cycle -> level=16, overflow stays 0, head advances by one.
- Disarm, re-arm and ts_clear:
  - Drop arm mid-stream -> no further entries, FIFO retained.
  - Re-arm -> overflow cleared; the first count_valid only primes, with no event even if it equals match_a.
  - ts_clear pulse -> the next entry's ts counts from 0.
